framebuffer_scanout: RTL and testbench
======================================

Name: framebuffer_scanout

Overview:
- Reader side of the rasterizer's framebuffer: the rasterizer writes pixels in; this block reads them out and drives a VGA-style display.
- Generates horizontal/vertical display timing and issues framebuffer read addresses, with each framebuffer pixel scaled up by SCALE in both axes.
- Aligns returned RGB data with delayed sync/blank signals.
- Emits a vertical-blank start pulse so control logic can trigger the next rasterizer pass.

Parameters:
VERT_RESOLUTION, 60, framebuffer rows
HORIZ_RESOLUTION, 80, framebuffer columns
SCALE, 8, display pixels per framebuffer pixel per axis; power of two
H_ACTIVE, 640, active display columns; must equal HORIZ_RESOLUTION*SCALE
H_FRONT, 16, horizontal front porch cycles
H_SYNC, 96, hsync pulse cycles
H_BACK, 48, horizontal back porch cycles
V_ACTIVE, 480, active display lines; must equal VERT_RESOLUTION*SCALE
V_FRONT, 10, vertical front porch lines
V_SYNC, 2, vsync pulse lines
V_BACK, 33, vertical back porch lines
READ_LATENCY, 2, cycles from o_read_en to valid i_red/i_green/i_blue; 1..4

Ports:
i_clk  input  1  pixel clock
i_srst  input  1  synchronous reset, active-high
o_vert_read_addr  output  $clog2(VERT_RESOLUTION)  framebuffer row
o_horiz_read_addr  output  $clog2(HORIZ_RESOLUTION)  framebuffer column
o_read_en  output  1  read strobe
i_red, i_green, i_blue  input  4 each  read data, valid READ_LATENCY cycles after o_read_en
o_hsync  output  1  horizontal sync, active-low
o_vsync  output  1  vertical sync, active-low
o_red, o_green, o_blue  output  4 each  display colour
o_active  output  1  display data enable
o_vblank_start  output  1  one-cycle pulse at first cycle of line V_ACTIVE

Behaviour:
- One clock, i_clk. Reset i_srst is synchronous and active-high.
- Reset values:
  - h_count = v_count = 0.
  - o_read_en = 0; both read addresses = 0.
  - o_hsync = o_vsync = 1.
  - Colours = 0; o_active = 0; o_vblank_start = 0.
  - All pipeline delay stages cleared to the blank, sync-deasserted state.
- Counters:
  - h_count runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK (800). It wraps to 0.
  - v_count increments when h_count wraps and runs 0..V_TOTAL-1 (525). It wraps to 0.
  - Counting starts the cycle after reset deasserts; counters never stall.
- Stage 0, combinational from the counters and registered into the outputs:
  - act = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
  - hs = h_count in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vs = v_count in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC).
  - When act: o_read_en <= 1, o_horiz_read_addr <= h_count >> log2(SCALE), o_vert_read_addr <= v_count >> log2(SCALE).
  - When not act: o_read_en <= 0 and both addresses <= 0.
- Data alignment:
  - act, hs and vs are delayed through a shift register of length READ_LATENCY+1, measured from the cycle o_read_en is registered.
  - Display outputs are registered on the final stage: o_active = delayed act; o_hsync = ~delayed hs; o_vsync = ~delayed vs.
  - Colours = input data when delayed act, else 0.
  - Total latency from counter value to display pins = READ_LATENCY+2 cycles. This latency is the same for sync and colour.
- o_vblank_start:
  - Registered pulse for exactly one cycle when h_count==0 && v_count==V_ACTIVE.
  - Not delayed through the pipeline, so it leads display-side blanking.
- Read data is not sampled when the delayed act is 0; garbage on i_* then must not reach the outputs.
- Mid-frame reset returns all outputs to reset values on the next edge. The first READ_LATENCY+2 cycles after release show blank data and deasserted syncs. No stale pipeline data is emitted.
- Boundaries:
  - Last active column (639) maps to address 79; last active line (479) maps to row 59.
  - Column 640 deasserts o_read_en.
  - Reads are never issued during porches or sync.

Test Plan:
- Reset held 5 cycles, then released -> all outputs hold reset values during reset. The first o_read_en rises one cycle after release with addresses (0,0). o_active first rises READ_LATENCY+2 = 4 cycles after release.
- Free-run 2 frames -> o_vblank_start pulses exactly 420000 cycles apart. o_hsync is low for 96 consecutive cycles every 800 cycles. o_vsync is low for 2 lines = 1600 cycles per frame.
- Framebuffer model returns red = col[3:0], green = row[3:0] with latency 2; check pixel at display (x=17, y=9) -> o_red = 2, o_green = 1. Check pixel at (639,479) -> o_red = 79&15 = 15, o_green = 59&15 = 11.
- Count reads over one line -> each address 0..79 is issued on 8 consecutive cycles. No reads are issued in cycles 640..799.
- Drive i_* = 4'hF constantly -> outside o_active all colours = 0. Count exactly 307200 o_active cycles per frame.
- Assert i_srst for 1 cycle at v_count=200, h_count=300 -> next edge shows o_read_en = 0, colours = 0, syncs = 1. Counters restart at (0,0), and timing of the subsequent frame matches the first scenario.

Source files
------------

// File: rtl/framebuffer_scanout.sv
// VGA-style scanout for the rasterizer framebuffer: display timing, scaled read
// addressing, and a delay pipeline that lines sync/blank up with returned pixel data.
module framebuffer_scanout #(
  parameter int VERT_RESOLUTION  = 60,
  parameter int HORIZ_RESOLUTION = 80,
  parameter int SCALE            = 8,
  parameter int H_ACTIVE         = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter int READ_LATENCY     = 2
) (
  input  logic                                i_clk,
  input  logic                                i_srst,
  output logic [$clog2(VERT_RESOLUTION)-1:0]  o_vert_read_addr,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0] o_horiz_read_addr,
  output logic                                o_read_en,
  input  logic [3:0]                          i_red,
  input  logic [3:0]                          i_green,
  input  logic [3:0]                          i_blue,
  output logic                                o_hsync,
  output logic                                o_vsync,
  output logic [3:0]                          o_red,
  output logic [3:0]                          o_green,
  output logic [3:0]                          o_blue,
  output logic                                o_active,
  output logic                                o_vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HC_W    = $clog2(H_TOTAL + 1);
  localparam int VC_W    = $clog2(V_TOTAL + 1);
  localparam int HA_W    = $clog2(HORIZ_RESOLUTION);
  localparam int VA_W    = $clog2(VERT_RESOLUTION);
  localparam int SH      = $clog2(SCALE);
  localparam int RL      = READ_LATENCY;

  localparam logic [HC_W-1:0] H_LAST    = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT_C   = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_START  = HC_W'(H_ACTIVE + H_FRONT);
  localparam logic [HC_W-1:0] HS_END    = HC_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VC_W-1:0] V_LAST    = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT_C   = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_START  = VC_W'(V_ACTIVE + V_FRONT);
  localparam logic [VC_W-1:0] VS_END    = VC_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HC_W-1:0] h_count;
  logic [VC_W-1:0] v_count;
  logic            act;
  logic            hs;
  logic            vs;
  logic            vblank_hit;
  logic [RL:0]     act_pipe;
  logic [RL:0]     hs_pipe;
  logic [RL:0]     vs_pipe;

  // Free-running raster counters; they never stall.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  always_comb begin
    act        = (h_count < H_ACT_C) && (v_count < V_ACT_C);
    hs         = (h_count >= HS_START) && (h_count < HS_END);
    vs         = (v_count >= VS_START) && (v_count < VS_END);
    vblank_hit = (h_count == '0) && (v_count == V_ACT_C);
  end

  // Read strobe and address are registered together; the framebuffer answers
  // READ_LATENCY cycles after o_read_en, with no backpressure in either direction.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      o_read_en         <= 1'b0;
      o_horiz_read_addr <= '0;
      o_vert_read_addr  <= '0;
      o_vblank_start    <= 1'b0;
      act_pipe          <= '0;
      hs_pipe           <= '0;
      vs_pipe           <= '0;
    end else begin
      o_read_en         <= act;
      o_horiz_read_addr <= act ? HA_W'(h_count >> SH) : '0;
      o_vert_read_addr  <= act ? VA_W'(v_count >> SH) : '0;
      o_vblank_start    <= vblank_hit;
      act_pipe          <= {act_pipe[RL-1:0], act};
      hs_pipe           <= {hs_pipe[RL-1:0], hs};
      vs_pipe           <= {vs_pipe[RL-1:0], vs};
    end
  end

  // Final stage meets the returned pixel; data outside the active window is dropped.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      o_active <= 1'b0;
      o_hsync  <= 1'b1;
      o_vsync  <= 1'b1;
      o_red    <= 4'h0;
      o_green  <= 4'h0;
      o_blue   <= 4'h0;
    end else begin
      o_active <= act_pipe[RL];
      o_hsync  <= ~hs_pipe[RL];
      o_vsync  <= ~vs_pipe[RL];
      o_red    <= act_pipe[RL] ? i_red   : 4'h0;
      o_green  <= act_pipe[RL] ? i_green : 4'h0;
      o_blue   <= act_pipe[RL] ? i_blue  : 4'h0;
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout on a shrunken raster so several frames and
// mid-frame resets fit in a short run; a latency-modelled framebuffer feeds it.
module tb_framebuffer_scanout;

  localparam int VRES     = 6;
  localparam int HRES     = 8;
  localparam int SCALE    = 2;
  localparam int H_ACTIVE = 16;
  localparam int H_FRONT  = 3;
  localparam int H_SYNC   = 4;
  localparam int H_BACK   = 5;
  localparam int V_ACTIVE = 12;
  localparam int V_FRONT  = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 3;
  localparam int RL       = 2;

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME   = H_TOTAL * V_TOTAL;
  localparam int VA_W    = $clog2(VRES);
  localparam int HA_W    = $clog2(HRES);
  localparam int DISP_W  = 15;
  localparam int RD_W    = 2 + VA_W + HA_W;
  localparam int REQ_W   = 1 + VA_W + HA_W;
  localparam logic [DISP_W-1:0] BLANK = {1'b0, 1'b1, 1'b1, 12'h000};

  logic            clk;
  logic            i_srst;
  logic [VA_W-1:0] o_vert_read_addr;
  logic [HA_W-1:0] o_horiz_read_addr;
  logic            o_read_en;
  logic [3:0]      i_red, i_green, i_blue;
  logic            o_hsync, o_vsync;
  logic [3:0]      o_red, o_green, o_blue;
  logic            o_active, o_vblank_start;

  framebuffer_scanout #(
    .VERT_RESOLUTION(VRES), .HORIZ_RESOLUTION(HRES), .SCALE(SCALE),
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .READ_LATENCY(RL)
  ) dut (
    .i_clk(clk),
    .i_srst(i_srst),
    .o_vert_read_addr(o_vert_read_addr),
    .o_horiz_read_addr(o_horiz_read_addr),
    .o_read_en(o_read_en),
    .i_red(i_red),
    .i_green(i_green),
    .i_blue(i_blue),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_red(o_red),
    .o_green(o_green),
    .o_blue(o_blue),
    .o_active(o_active),
    .o_vblank_start(o_vblank_start)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [DISP_W-1:0] exp_q[$];
  logic [RD_W-1:0]   exp_rd_q[$];
  logic              in_reset = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
  endtask

  // Reference model: what the display should show for raster position p.
  function automatic logic [DISP_W-1:0] disp_at(input int p);
    int x, y, col, row;
    logic a, hs, vs;
    logic [3:0] r, g, b;
    x   = p % H_TOTAL;
    y   = p / H_TOTAL;
    col = x / SCALE;
    row = y / SCALE;
    a   = (x < H_ACTIVE) && (y < V_ACTIVE);
    hs  = (x >= H_ACTIVE + H_FRONT) && (x < H_ACTIVE + H_FRONT + H_SYNC);
    vs  = (y >= V_ACTIVE + V_FRONT) && (y < V_ACTIVE + V_FRONT + V_SYNC);
    r   = a ? 4'(col % 16) : 4'h0;
    g   = a ? 4'(row % 16) : 4'h0;
    b   = a ? 4'((col + row) % 16) : 4'h0;
    return {a, ~hs, ~vs, r, g, b};
  endfunction

  function automatic logic [RD_W-1:0] rd_at(input int p);
    int x, y;
    logic a, vb;
    x  = p % H_TOTAL;
    y  = p / H_TOTAL;
    a  = (x < H_ACTIVE) && (y < V_ACTIVE);
    vb = (p == V_ACTIVE * H_TOTAL);
    if (a) return {1'b1, vb, VA_W'(y / SCALE), HA_W'(x / SCALE)};
    return {1'b0, vb, VA_W'(0), HA_W'(0)};
  endfunction

  // Stimulus side of the scoreboard: one expected response per clock edge.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      if (i_srst) begin
        k = 0;
        in_reset = 1'b1;
        exp_q.push_back(BLANK);
        exp_rd_q.push_back('0);
      end else begin
        in_reset = 1'b0;
        k++;
        exp_q.push_back((k <= RL + 1) ? BLANK : disp_at((k - RL - 2) % FRAME));
        exp_rd_q.push_back(rd_at((k - 1) % FRAME));
      end
    end
  end

  // Framebuffer model: answers a read RL cycles later, garbage otherwise.
  initial begin
    logic [REQ_W-1:0] req[RL+1];
    logic [VA_W-1:0]  row;
    logic [HA_W-1:0]  col;
    for (int i = 0; i <= RL; i++) req[i] = '0;
    i_red = 4'h0; i_green = 4'h0; i_blue = 4'h0;
    forever begin
      @(negedge clk);
      for (int i = RL; i > 0; i--) req[i] = req[i-1];
      req[0] = {o_read_en, o_vert_read_addr, o_horiz_read_addr};
      {row, col} = req[RL][REQ_W-2:0];
      if (req[RL][REQ_W-1]) begin
        i_red   = 4'(col);
        i_green = 4'(row);
        i_blue  = 4'(32'(col) + 32'(row));
      end else if ($urandom_range(0, 1) == 1) begin
        i_red = 4'hF; i_green = 4'hF; i_blue = 4'hF;
      end else begin
        i_red   = 4'($urandom_range(0, 15));
        i_green = 4'($urandom_range(0, 15));
        i_blue  = 4'($urandom_range(0, 15));
      end
    end
  end

  // Monitor: pops and compares every cycle, plus frame-level totals.
  initial begin
    logic [DISP_W-1:0] d;
    logic [RD_W-1:0]   r;
    int interval, act_cnt;
    logic have_prev;
    interval = 0; act_cnt = 0; have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        d = exp_q.pop_front();
        r = exp_rd_q.pop_front();
        check("display", 32'({o_active, o_hsync, o_vsync, o_red, o_green, o_blue}), 32'(d));
        check("read_side", 32'({o_read_en, o_vblank_start, o_vert_read_addr, o_horiz_read_addr}), 32'(r));
        if (in_reset) begin
          have_prev = 1'b0;
        end else begin
          interval++;
          act_cnt += int'(o_active);
          if (o_vblank_start) begin
            if (have_prev) begin
              check("vblank_interval", 32'(interval), 32'(FRAME));
              check("active_per_frame", 32'(act_cnt), 32'(H_ACTIVE * V_ACTIVE));
            end
            have_prev = 1'b1;
            interval  = 0;
            act_cnt   = 0;
          end
        end
      end
    end
  end

  task automatic pulse_reset(input int cycles);
    i_srst = 1'b1;
    repeat (cycles) @(negedge clk);
    i_srst = 1'b0;
  endtask

  // Driver: initial reset, free run, then mid-frame resets.
  initial begin
    i_srst = 1'b1;
    repeat (5) @(negedge clk);
    i_srst = 1'b0;
    repeat (3 * FRAME + 7) @(negedge clk);
    // reset part-way down the active area (line 7, column 10 after release)
    repeat (FRAME - 7 + 7 * H_TOTAL + 10) @(negedge clk);
    pulse_reset(1);
    repeat (2 * FRAME + 30) @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      repeat ($urandom_range(20, FRAME)) @(negedge clk);
      pulse_reset($urandom_range(1, 3));
      repeat (2 * FRAME + 10) @(negedge clk);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
